// File: rtl/cpu_rd_mb.sv
// Multi-beat CPU read engine: splits a host read into memory beats and buffers
// the returned words in a FIFO whose free space gates new beat requests.
module cpu_rd_mb #(
  parameter int DW        = 32,
  parameter int MAX_BEATS = 4,
  parameter int DEPTH     = 4,
  parameter int LW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic          mem_clk,
  input  logic          hreset_n,
  input  logic          g_memrd,
  input  logic          h_svga_sel,
  input  logic          c_misc_b1,
  input  logic [LW-1:0] rd_beats,
  input  logic          cpu_rd_gnt,
  output logic          cpu_rd_req,
  output logic          cpu_rd_svga_req,
  input  logic          svga_ack,
  input  logic          mem_data_valid,
  input  logic [DW-1:0] m_t_mem_data_in,
  input  logic          g_data_pop,
  output logic [DW-1:0] g_graph_data_in,
  output logic          g_data_avail,
  output logic          m_memrd_ready_n,
  output logic          m_cpurd_s0,
  output logic [2:0]    cpurd_state,
  output logic          rd_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_REQ   = 3'b001,
    S_ISSUE = 3'b011,
    S_WAIT  = 3'b111,
    S_DONE  = 3'b110
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] beats_left_q, beats_left_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_err_q, rd_err_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          start, accept, ret_ok, full, push, pop;
  logic [CW:0]   in_flight;

  always_comb begin
    start         = g_memrd & h_svga_sel & c_misc_b1;
    // Credit counts both buffered words and beats still owed by memory.
    in_flight     = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
    cpu_rd_svga_req = (state_q == S_ISSUE) && (in_flight < DEPTH_X);
    accept        = cpu_rd_svga_req & svga_ack;
    ret_ok        = mem_data_valid & ((outstanding_q != '0) | accept);
    full          = (fifo_count_q == DEPTH_C);
    push          = ret_ok & ~full;
    pop           = g_data_pop & (fifo_count_q != '0);

    outstanding_d = outstanding_q + CW'(accept) - CW'(ret_ok);
    fifo_count_d  = fifo_count_q + CW'(push) - CW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    rd_err_d      = rd_err_q | (mem_data_valid & ~ret_ok) | (ret_ok & full);

    state_d       = state_q;
    beats_left_d  = beats_left_q;
    case (state_q)
      S_IDLE: if (start) begin
        beats_left_d = rd_beats;
        state_d      = S_REQ;
      end
      S_REQ:   if (cpu_rd_gnt) state_d = S_ISSUE;
      S_ISSUE: if (accept) begin
        if (beats_left_q == '0) state_d = S_WAIT;
        else                    beats_left_d = beats_left_q - LW'(1);
      end
      S_WAIT:  if (outstanding_q == '0) state_d = S_DONE;
      S_DONE:  if (fifo_count_d == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (!hreset_n) begin
      state_q       <= S_IDLE;
      beats_left_q  <= '0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      beats_left_q  <= beats_left_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_err_q      <= rd_err_d;
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge mem_clk) begin
    if (push) mem_q[wr_ptr_q] <= m_t_mem_data_in;
  end

  assign cpu_rd_req      = (state_q == S_REQ) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign m_cpurd_s0      = (state_q == S_IDLE);
  assign cpurd_state     = state_q;
  assign g_data_avail    = (fifo_count_q != '0);
  assign m_memrd_ready_n = ~g_data_avail;
  assign g_graph_data_in = mem_q[rd_ptr_q];
  assign rd_err          = rd_err_q;

endmodule

// File: tb/tb_cpu_rd_mb.sv
// Directed bench for cpu_rd_mb (DEPTH=4, MAX_BEATS=8): single beat, burst with
// back-pressure, streaming, spurious return, mid-read reset, ignored restart.
module tb_cpu_rd_mb;
  logic        mem_clk = 1'b0;
  logic        hreset_n, g_memrd, h_svga_sel, c_misc_b1;
  logic [2:0]  rd_beats;
  logic        cpu_rd_gnt, cpu_rd_req, cpu_rd_svga_req, svga_ack, mem_data_valid;
  logic [31:0] m_t_mem_data_in, g_graph_data_in;
  logic        g_data_pop, g_data_avail, m_memrd_ready_n, m_cpurd_s0, rd_err;
  logic [2:0]  cpurd_state;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  cpu_rd_mb #(.DW(32), .MAX_BEATS(8), .DEPTH(4)) dut (
    .mem_clk(mem_clk), .hreset_n(hreset_n), .g_memrd(g_memrd),
    .h_svga_sel(h_svga_sel), .c_misc_b1(c_misc_b1), .rd_beats(rd_beats),
    .cpu_rd_gnt(cpu_rd_gnt), .cpu_rd_req(cpu_rd_req),
    .cpu_rd_svga_req(cpu_rd_svga_req), .svga_ack(svga_ack),
    .mem_data_valid(mem_data_valid), .m_t_mem_data_in(m_t_mem_data_in),
    .g_data_pop(g_data_pop), .g_graph_data_in(g_graph_data_in),
    .g_data_avail(g_data_avail), .m_memrd_ready_n(m_memrd_ready_n),
    .m_cpurd_s0(m_cpurd_s0), .cpurd_state(cpurd_state), .rd_err(rd_err)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic test_reset();
    hreset_n = 1'b0;
    tick();
    tick();
    chk_cnt++; if (cpu_rd_req !== 1'b0) $display("FAIL rst_req: got %b want 0", cpu_rd_req); else pass_cnt++;
    chk_cnt++; if (cpu_rd_svga_req !== 1'b0) $display("FAIL rst_svga: got %b want 0", cpu_rd_svga_req); else pass_cnt++;
    chk_cnt++; if (g_data_avail !== 1'b0) $display("FAIL rst_avail: got %b want 0", g_data_avail); else pass_cnt++;
    chk_cnt++; if (m_memrd_ready_n !== 1'b1) $display("FAIL rst_ready_n: got %b want 1", m_memrd_ready_n); else pass_cnt++;
    chk_cnt++; if (m_cpurd_s0 !== 1'b1) $display("FAIL rst_s0: got %b want 1", m_cpurd_s0); else pass_cnt++;
    chk_cnt++; if (cpurd_state !== 3'b000) $display("FAIL rst_state: got %b want 000", cpurd_state); else pass_cnt++;
    chk_cnt++; if (rd_err !== 1'b0) $display("FAIL rst_err: got %b want 0", rd_err); else pass_cnt++;
    hreset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    rd_beats = 3'd0; g_memrd = 1'b1;
    tick();
    g_memrd = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b001) $display("FAIL single_req_state: got %b want 001", cpurd_state); else pass_cnt++;
    chk_cnt++; if (cpu_rd_req !== 1'b1) $display("FAIL single_req: got %b want 1", cpu_rd_req); else pass_cnt++;
    chk_cnt++; if (cpu_rd_svga_req !== 1'b0) $display("FAIL single_svga_pre: got %b want 0", cpu_rd_svga_req); else pass_cnt++;
    cpu_rd_gnt = 1'b1;
    tick();
    chk_cnt++; if (cpurd_state !== 3'b011) $display("FAIL single_issue_state: got %b want 011", cpurd_state); else pass_cnt++;
    chk_cnt++; if (cpu_rd_svga_req !== 1'b1) $display("FAIL single_svga: got %b want 1", cpu_rd_svga_req); else pass_cnt++;
    svga_ack = 1'b1;
    tick();
    svga_ack = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b111) $display("FAIL single_wait_state: got %b want 111", cpurd_state); else pass_cnt++;
    chk_cnt++; if (cpu_rd_svga_req !== 1'b0) $display("FAIL single_svga_wait: got %b want 0", cpu_rd_svga_req); else pass_cnt++;
    mem_data_valid = 1'b1; m_t_mem_data_in = 32'hDEADBEEF;
    tick();
    mem_data_valid = 1'b0;
    chk_cnt++; if (g_data_avail !== 1'b1) $display("FAIL single_avail: got %b want 1", g_data_avail); else pass_cnt++;
    chk_cnt++; if (g_graph_data_in !== 32'hDEADBEEF) $display("FAIL single_data: got %h want deadbeef", g_graph_data_in); else pass_cnt++;
    chk_cnt++; if (m_memrd_ready_n !== 1'b0) $display("FAIL single_ready_n: got %b want 0", m_memrd_ready_n); else pass_cnt++;
    tick();
    cpu_rd_gnt = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b110) $display("FAIL single_done_state: got %b want 110", cpurd_state); else pass_cnt++;
    chk_cnt++; if (cpu_rd_req !== 1'b0) $display("FAIL single_done_req: got %b want 0", cpu_rd_req); else pass_cnt++;
    g_data_pop = 1'b1;
    tick();
    g_data_pop = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b000) $display("FAIL single_idle_state: got %b want 000", cpurd_state); else pass_cnt++;
    chk_cnt++; if (m_memrd_ready_n !== 1'b1) $display("FAIL single_idle_ready_n: got %b want 1", m_memrd_ready_n); else pass_cnt++;
    chk_cnt++; if (m_cpurd_s0 !== 1'b1) $display("FAIL single_idle_s0: got %b want 1", m_cpurd_s0); else pass_cnt++;
  endtask

  // Memory acks every request and returns data one clock later; pops begin
  // only after the fourth word is buffered.
  task automatic test_burst_backpressure();
    int issued = 0, returned = 0, pushed = 0, popped = 0, cyc = 0;
    bit pend = 0, pop_en = 0, exp_req = 0, dut_drop = 0;
    rd_beats = 3'd7; g_memrd = 1'b1;
    tick();
    g_memrd = 1'b0; cpu_rd_gnt = 1'b1;
    tick();
    svga_ack = 1'b1;
    while (popped < 8 && cyc < 80) begin
      mem_data_valid  = pend;
      m_t_mem_data_in = 32'h10 + 32'(returned);
      exp_req = (issued < 8) && (((pushed - popped) + (issued - returned)) < 4);
      if (issued < 8 && cpu_rd_svga_req === 1'b0) dut_drop = 1;
      chk_cnt++; if (cpu_rd_svga_req !== exp_req) $display("FAIL burst_svga_req cyc%0d: got %b want %b", cyc, cpu_rd_svga_req, exp_req); else pass_cnt++;
      if (pushed >= 4) pop_en = 1;
      g_data_pop = pop_en && (pushed > popped);
      if (g_data_pop) begin
        chk_cnt++; if (g_graph_data_in !== 32'h10 + 32'(popped)) $display("FAIL burst_data %0d: got %h want %h", popped, g_graph_data_in, 32'h10 + 32'(popped)); else pass_cnt++;
      end
      tick();
      if (mem_data_valid) begin returned++; pushed++; end
      if (g_data_pop) popped++;
      pend = exp_req;
      if (exp_req) issued++;
      cyc++;
    end
    mem_data_valid = 1'b0; g_data_pop = 1'b0; svga_ack = 1'b0;
    chk_cnt++; if (popped != 8) $display("FAIL burst_timeout: popped %0d want 8", popped); else pass_cnt++;
    chk_cnt++; if (dut_drop !== 1'b1) $display("FAIL burst_req_drop: got %b want 1", dut_drop); else pass_cnt++;
    chk_cnt++; if (rd_err !== 1'b0) $display("FAIL burst_err: got %b want 0", rd_err); else pass_cnt++;
    tick();
    tick();
    cpu_rd_gnt = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b000) $display("FAIL burst_end_state: got %b want 000", cpurd_state); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    rd_beats = 3'd7; g_memrd = 1'b1;
    tick();
    g_memrd = 1'b0; cpu_rd_gnt = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      svga_ack        = (k <= 7);
      mem_data_valid  = (k >= 1 && k <= 8);
      m_t_mem_data_in = 32'h20 + 32'(k) - 32'd1;
      g_data_pop      = (k >= 2);
      if (k <= 7) begin
        chk_cnt++; if (cpu_rd_svga_req !== 1'b1) $display("FAIL b2b_svga k%0d: got %b want 1", k, cpu_rd_svga_req); else pass_cnt++;
      end
      if (k >= 2) begin
        chk_cnt++; if (g_graph_data_in !== 32'h20 + 32'(k) - 32'd2) $display("FAIL b2b_data k%0d: got %h want %h", k, g_graph_data_in, 32'h20 + 32'(k) - 32'd2); else pass_cnt++;
        chk_cnt++; if (g_data_avail !== 1'b1) $display("FAIL b2b_avail k%0d: got %b want 1", k, g_data_avail); else pass_cnt++;
      end
      if (k == 8) begin
        chk_cnt++; if (cpurd_state !== 3'b111) $display("FAIL b2b_wait_state: got %b want 111", cpurd_state); else pass_cnt++;
      end
      tick();
    end
    svga_ack = 1'b0; mem_data_valid = 1'b0; g_data_pop = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b110) $display("FAIL b2b_done_state: got %b want 110", cpurd_state); else pass_cnt++;
    chk_cnt++; if (g_data_avail !== 1'b0) $display("FAIL b2b_empty: got %b want 0", g_data_avail); else pass_cnt++;
    tick();
    cpu_rd_gnt = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b000) $display("FAIL b2b_idle_state: got %b want 000", cpurd_state); else pass_cnt++;
    chk_cnt++; if (rd_err !== 1'b0) $display("FAIL b2b_err: got %b want 0", rd_err); else pass_cnt++;
  endtask

  task automatic test_spurious();
    mem_data_valid = 1'b1; m_t_mem_data_in = 32'h00000BAD;
    tick();
    mem_data_valid = 1'b0;
    chk_cnt++; if (rd_err !== 1'b1) $display("FAIL spur_err: got %b want 1", rd_err); else pass_cnt++;
    chk_cnt++; if (g_data_avail !== 1'b0) $display("FAIL spur_avail: got %b want 0", g_data_avail); else pass_cnt++;
    tick();
    tick();
    chk_cnt++; if (rd_err !== 1'b1) $display("FAIL spur_sticky: got %b want 1", rd_err); else pass_cnt++;
    chk_cnt++; if (g_data_avail !== 1'b0) $display("FAIL spur_avail_later: got %b want 0", g_data_avail); else pass_cnt++;
    chk_cnt++; if (cpurd_state !== 3'b000) $display("FAIL spur_state: got %b want 000", cpurd_state); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    hreset_n = 1'b0;
    tick();
    hreset_n = 1'b1;
    rd_beats = 3'd1; g_memrd = 1'b1;
    tick();
    g_memrd = 1'b0; cpu_rd_gnt = 1'b1;
    tick();
    svga_ack = 1'b1;
    tick();
    tick();
    svga_ack = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b111) $display("FAIL mid_wait_state: got %b want 111", cpurd_state); else pass_cnt++;
    hreset_n = 1'b0;
    tick();
    chk_cnt++; if (cpu_rd_req !== 1'b0) $display("FAIL mid_rst_req: got %b want 0", cpu_rd_req); else pass_cnt++;
    chk_cnt++; if (cpu_rd_svga_req !== 1'b0) $display("FAIL mid_rst_svga: got %b want 0", cpu_rd_svga_req); else pass_cnt++;
    chk_cnt++; if (g_data_avail !== 1'b0) $display("FAIL mid_rst_avail: got %b want 0", g_data_avail); else pass_cnt++;
    chk_cnt++; if (m_memrd_ready_n !== 1'b1) $display("FAIL mid_rst_ready_n: got %b want 1", m_memrd_ready_n); else pass_cnt++;
    chk_cnt++; if (m_cpurd_s0 !== 1'b1) $display("FAIL mid_rst_s0: got %b want 1", m_cpurd_s0); else pass_cnt++;
    chk_cnt++; if (cpurd_state !== 3'b000) $display("FAIL mid_rst_state: got %b want 000", cpurd_state); else pass_cnt++;
    chk_cnt++; if (rd_err !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", rd_err); else pass_cnt++;
    hreset_n = 1'b1; cpu_rd_gnt = 1'b0;
    tick();
    rd_beats = 3'd0; g_memrd = 1'b1;
    tick();
    g_memrd = 1'b0; cpu_rd_gnt = 1'b1;
    tick();
    svga_ack = 1'b1;
    tick();
    svga_ack = 1'b0; mem_data_valid = 1'b1; m_t_mem_data_in = 32'h5A5A1234;
    tick();
    mem_data_valid = 1'b0;
    chk_cnt++; if (g_graph_data_in !== 32'h5A5A1234) $display("FAIL mid_new_data: got %h want 5a5a1234", g_graph_data_in); else pass_cnt++;
    tick();
    cpu_rd_gnt = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b110) $display("FAIL mid_new_done: got %b want 110", cpurd_state); else pass_cnt++;
    g_data_pop = 1'b1;
    tick();
    g_data_pop = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b000) $display("FAIL mid_new_idle: got %b want 000", cpurd_state); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int issued = 0, nret = 0;
    bit pend = 0, cur;
    rd_beats = 3'd1; g_memrd = 1'b1;
    tick();
    g_memrd = 1'b0; cpu_rd_gnt = 1'b1;
    tick();
    svga_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      mem_data_valid  = pend;
      m_t_mem_data_in = 32'h30 + 32'(nret);
      g_memrd  = (c == 0);
      rd_beats = (c == 0) ? 3'd3 : 3'd1;
      cur = cpu_rd_svga_req;
      tick();
      if (mem_data_valid) nret++;
      pend = cur;
      if (cur) issued++;
    end
    g_memrd = 1'b0; svga_ack = 1'b0; mem_data_valid = 1'b0;
    chk_cnt++; if (issued != 2) $display("FAIL busy_beats: got %0d want 2", issued); else pass_cnt++;
    chk_cnt++; if (cpurd_state !== 3'b110) $display("FAIL busy_done_state: got %b want 110", cpurd_state); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      g_data_pop = 1'b1;
      chk_cnt++; if (g_graph_data_in !== 32'h30 + 32'(i)) $display("FAIL busy_data %0d: got %h want %h", i, g_graph_data_in, 32'h30 + 32'(i)); else pass_cnt++;
      tick();
    end
    g_data_pop = 1'b0; cpu_rd_gnt = 1'b0;
    chk_cnt++; if (cpurd_state !== 3'b000) $display("FAIL busy_idle_state: got %b want 000", cpurd_state); else pass_cnt++;
    chk_cnt++; if (rd_err !== 1'b0) $display("FAIL busy_err: got %b want 0", rd_err); else pass_cnt++;
  endtask

  initial begin
    hreset_n = 1'b0; g_memrd = 1'b0; h_svga_sel = 1'b1; c_misc_b1 = 1'b1;
    rd_beats = 3'd0; cpu_rd_gnt = 1'b0; svga_ack = 1'b0; mem_data_valid = 1'b0;
    m_t_mem_data_in = 32'd0; g_data_pop = 1'b0;
    test_reset();
    test_single();
    test_burst_backpressure();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
